// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader takes the slave side; the host/memory side takes the master side.
interface imem_loader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: packs a big-endian byte stream into 24-bit instruction words,
// writes them to sequential addresses from 0, and holds the core until done.
module imem_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] length,
  imem_loader_if.slave      bus,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [1:0]        idx_reg, idx_next;
  logic [DATA_W-1:0] word_reg, word_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W-1:0] len_reg, len_next;
  logic [ADDR_W-1:0] addr_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      idx_reg   <= 2'd0;
      word_reg  <= '0;
      addr_reg  <= '0;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      word_reg  <= word_next;
      addr_reg  <= addr_next;
      len_reg   <= len_next;
    end
  end

  // The write address doubles as the word counter: both start at 0 and step together.
  assign addr_inc = addr_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    word_next  = word_reg;
    addr_next  = addr_reg;
    len_next   = len_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          addr_next  = '0;
          idx_next   = 2'd0;
          len_next   = length;
          state_next = (length == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (bus.byte_valid) begin
          case (idx_reg)
            2'd0:    word_next[23:16] = bus.byte_in;
            2'd1:    word_next[15:8]  = bus.byte_in;
            default: word_next[7:0]   = bus.byte_in;
          endcase
          if (idx_reg == 2'd2) begin
            idx_next   = 2'd0;
            state_next = WRITE;
          end else begin
            idx_next = idx_reg + 2'd1;
          end
        end
      end
      WRITE: begin
        addr_next  = addr_inc;
        state_next = (addr_inc == len_reg) ? DONE : RECV;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode only registered state, so nothing is combinational from inputs.
  assign bus.byte_ready = (state_reg == RECV);
  assign bus.mem_we     = (state_reg == WRITE);
  assign bus.mem_addr   = addr_reg;
  assign bus.mem_wdata  = word_reg;
  assign busy           = (state_reg == RECV) || (state_reg == WRITE);
  assign done           = (state_reg == DONE);
  assign cpu_hold       = (state_reg != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: expected writes are derived from the accepted
// byte list (word k = bytes 3k..3k+2 at address k) and compared with observed writes.
module tb_imem_loader;
  localparam int AW = 16;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] length = '0;
  logic          busy, done, cpu_hold;

  imem_loader_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

  imem_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .length   (length),
    .bus      (ifc.slave),
    .busy     (busy),
    .done     (done),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0]    txq[$];
  logic [AW-1:0] waddr[$];
  logic [DW-1:0] wdata[$];
  int            wcyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ifc.mem_we === 1'b1) begin
      waddr.push_back(ifc.mem_addr);
      wdata.push_back(ifc.mem_wdata);
      wcyc.push_back(cyc);
    end
  end

  function automatic logic [DW-1:0] exp_word(input int k);
    return {txq[3*k], txq[3*k+1], txq[3*k+2]};
  endfunction

  task automatic clear_log();
    waddr.delete();
    wdata.delete();
    wcyc.delete();
  endtask

  task automatic fill_tx(input int nbytes);
    txq.delete();
    for (int i = 0; i < nbytes; i++) txq.push_back(8'($urandom));
  endtask

  // Ends on the negedge one cycle after the start edge.
  task automatic do_start(input logic [AW-1:0] len, input bit with_byte);
    @(negedge clk);
    start  = 1'b1;
    length = len;
    if (with_byte) begin
      ifc.byte_valid = 1'b1;
      ifc.byte_in    = 8'hA5;
    end
    @(negedge clk);
    start          = 1'b0;
    ifc.byte_valid = 1'b0;
    length         = AW'($urandom);
  endtask

  // Entered and left on a negedge; stops right after the last byte is accepted.
  task automatic send(input int gap_pct, input bit poke);
    int  i = 0;
    int  budget = 0;
    logic rdy;
    while (i < txq.size() && budget < 2000) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        ifc.byte_valid = 1'b0;
        ifc.byte_in    = 8'($urandom);
      end else begin
        ifc.byte_valid = 1'b1;
        ifc.byte_in    = txq[i];
      end
      if (poke) begin
        start  = ($urandom_range(0, 2) == 0);
        length = AW'($urandom);
      end
      rdy = ifc.byte_ready;
      @(posedge clk);
      if (ifc.byte_valid && rdy) i++;
      budget++;
      @(negedge clk);
    end
    ifc.byte_valid = 1'b0;
    start          = 1'b0;
    checks++;
    if (i != txq.size()) begin
      errors++;
      $display("FAIL send_timeout: accepted %0d bytes, required %0d", i, txq.size());
    end
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++; if (ifc.byte_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", ifc.byte_ready); end
    checks++; if (ifc.mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b want 0", ifc.mem_we); end
    checks++; if (ifc.mem_addr !== 16'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", ifc.mem_addr); end
    checks++; if (ifc.mem_wdata !== 24'h0) begin errors++; $display("FAIL rst_wdata: got %h want 0", ifc.mem_wdata); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_hold: got %b want 1", cpu_hold); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    // Reach DONE, then reset asynchronously mid-cycle and expect instant effect.
    do_start(16'd0, 1'b0);
    #2 rst = 1'b0;
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_async_done: got %b want 0", done); end
    checks++; if (cpu_hold !== 1'b1) begin errors++; $display("FAIL rst_async_hold: got %b want 1", cpu_hold); end
    @(negedge clk);
    rst = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single();
    clear_log();
    txq = '{8'hAB, 8'hCD, 8'hEF};
    do_start(16'd1, 1'b0);
    checks++; if (ifc.byte_ready !== 1'b1) begin errors++; $display("FAIL single_latency: byte_ready=%b want 1", ifc.byte_ready); end
    send(0, 1'b0);
    checks++; if (ifc.mem_we !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL single_write_cycle: we=%b done=%b want 1 0", ifc.mem_we, done); end
    @(negedge clk);
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin errors++; $display("FAIL single_done: done=%b hold=%b want 1 0", done, cpu_hold); end
    checks++; if (ifc.byte_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_idle: ready=%b busy=%b want 0 0", ifc.byte_ready, busy); end
    checks++;
    if (waddr.size() != 1) begin errors++; $display("FAIL single_count: got %0d writes want 1", waddr.size()); end
    else if (waddr[0] !== 16'h0 || wdata[0] !== 24'hABCDEF) begin
      errors++; $display("FAIL single_word: got %h@%h want abcdef@0000", wdata[0], waddr[0]);
    end
    $display("test_single done writes=%0d", waddr.size());
  endtask

  task automatic test_gaps();
    clear_log();
    txq.delete();
    for (int i = 1; i <= 9; i++) txq.push_back(8'(i));
    do_start(16'd3, 1'b0);
    send(40, 1'b0);
    wait_done(50);
    checks++;
    if (waddr.size() != 3) begin errors++; $display("FAIL gaps_count: got %0d writes want 3", waddr.size()); end
    for (int k = 0; k < waddr.size() && k < 3; k++) begin
      checks++;
      if (waddr[k] !== AW'(k) || wdata[k] !== exp_word(k)) begin
        errors++; $display("FAIL gaps_word%0d: got %h@%h want %h@%h", k, wdata[k], waddr[k], exp_word(k), AW'(k));
      end
      if (k > 0) begin
        checks++;
        if (wcyc[k] - wcyc[k-1] < 4) begin
          errors++; $display("FAIL gaps_spacing%0d: got %0d cycles want >=4", k, wcyc[k] - wcyc[k-1]);
        end
      end
    end
    $display("test_gaps done writes=%0d", waddr.size());
  endtask

  task automatic test_zero();
    clear_log();
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_pre_done: got %b want 0", done); end
    do_start(16'd0, 1'b0);
    checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_done: done=%b hold=%b busy=%b want 1 0 0", done, cpu_hold, busy);
    end
    repeat (4) @(negedge clk);
    checks++; if (waddr.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", waddr.size()); end
    $display("test_zero done writes=%0d", waddr.size());
  endtask

  task automatic test_abort();
    clear_log();
    fill_tx(5);
    do_start(16'd4, 1'b0);
    send(20, 1'b0);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (waddr.size() != 1) begin errors++; $display("FAIL abort_count: got %0d writes want 1", waddr.size()); end
    else if (waddr[0] !== 16'h0 || wdata[0] !== exp_word(0)) begin
      errors++; $display("FAIL abort_word: got %h@%h want %h@0000", wdata[0], waddr[0], exp_word(0));
    end
    checks++; if (ifc.byte_ready !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL abort_ctrl: ready=%b busy=%b hold=%b done=%b want 0 0 1 0", ifc.byte_ready, busy, cpu_hold, done);
    end
    checks++; if (ifc.mem_addr !== 16'h0 || ifc.mem_wdata !== 24'h0) begin
      errors++; $display("FAIL abort_bus: addr=%h wdata=%h want 0 0", ifc.mem_addr, ifc.mem_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_log();
    fill_tx(6);
    do_start(16'd2, 1'b0);
    send(20, 1'b0);
    wait_done(50);
    checks++;
    if (waddr.size() != 2) begin errors++; $display("FAIL restart_count: got %0d writes want 2", waddr.size()); end
    for (int k = 0; k < waddr.size() && k < 2; k++) begin
      checks++;
      if (waddr[k] !== AW'(k) || wdata[k] !== exp_word(k)) begin
        errors++; $display("FAIL restart_word%0d: got %h@%h want %h@%h", k, wdata[k], waddr[k], exp_word(k), AW'(k));
      end
    end
    $display("test_abort done writes=%0d", waddr.size());
  endtask

  task automatic test_ignored();
    clear_log();
    fill_tx(9);
    do_start(16'd3, 1'b1);
    send(25, 1'b1);
    wait_done(50);
    checks++;
    if (waddr.size() != 3) begin errors++; $display("FAIL ign_count: got %0d writes want 3", waddr.size()); end
    for (int k = 0; k < waddr.size() && k < 3; k++) begin
      checks++;
      if (waddr[k] !== AW'(k) || wdata[k] !== exp_word(k)) begin
        errors++; $display("FAIL ign_word%0d: got %h@%h want %h@%h", k, wdata[k], waddr[k], exp_word(k), AW'(k));
      end
    end
    for (int c = 0; c < 4; c++) begin
      ifc.byte_valid = 1'b1;
      ifc.byte_in    = 8'($urandom);
      checks++;
      if (ifc.byte_ready !== 1'b0) begin errors++; $display("FAIL ign_done_ready: got %b want 0", ifc.byte_ready); end
      @(negedge clk);
    end
    ifc.byte_valid = 1'b0;
    checks++; if (waddr.size() != 3 || done !== 1'b1) begin
      errors++; $display("FAIL ign_done_hold: writes=%0d done=%b want 3 1", waddr.size(), done);
    end
    clear_log();
    fill_tx(6);
    do_start(16'd2, 1'b0);
    checks++; if (done !== 1'b0 || cpu_hold !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL ign_restart: done=%b hold=%b busy=%b want 0 1 1", done, cpu_hold, busy);
    end
    send(10, 1'b0);
    wait_done(50);
    checks++;
    if (waddr.size() != 2 || wdata[0] !== exp_word(0) || wdata[1] !== exp_word(1)) begin
      errors++; $display("FAIL ign_second_load: writes=%0d, required 2 words %h %h", waddr.size(), exp_word(0), exp_word(1));
    end
    $display("test_ignored done writes=%0d", waddr.size());
  endtask

  task automatic test_random();
    for (int t = 0; t < 4; t++) begin
      int len;
      len = $urandom_range(1, 6);
      clear_log();
      fill_tx(3 * len);
      do_start(AW'(len), 1'($urandom_range(0, 1)));
      send($urandom_range(0, 50), 1'b1);
      wait_done(50);
      checks++;
      if (waddr.size() != len) begin errors++; $display("FAIL rand%0d_count: got %0d writes want %0d", t, waddr.size(), len); end
      for (int k = 0; k < waddr.size() && k < len; k++) begin
        checks++;
        if (waddr[k] !== AW'(k) || wdata[k] !== exp_word(k)) begin
          errors++; $display("FAIL rand%0d_word%0d: got %h@%h want %h@%h", t, k, wdata[k], waddr[k], exp_word(k), AW'(k));
        end
      end
      $display("test_random load %0d len=%0d writes=%0d", t, len, waddr.size());
    end
  endtask

  initial begin
    ifc.byte_in    = 8'h00;
    ifc.byte_valid = 1'b0;
    test_reset();
    test_single();
    test_gaps();
    test_zero();
    test_abort();
    test_ignored();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
